// File: rtl/and_pipe_pkg.sv
// Shared types and constants for the pipelined AND reduction stage.
// Stage payload: result word, per-chunk AND/NOR partials, final flags.
package and_pipe_pkg;

    localparam int STAGES_MAX = 4;
    localparam int STAT_W     = 16;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_CHUNK  = 8;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]           y;
        logic [DEF_WIDTH/DEF_CHUNK-1:0] andp;
        logic [DEF_WIDTH/DEF_CHUNK-1:0] norp;
        logic                           all;
        logic                           zero;
    } stage_t;

    function automatic int stage_bits(input int width, input int chunk);
        return width + 2 * (width / chunk) + 2;
    endfunction

    function automatic logic legal_cfg(input int width, input int chunk,
                                       input int stages);
        return (chunk > 0) && (width % chunk == 0) &&
               (stages >= 1) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/and_pipe_if.sv
// Valid/ready bundle for the AND pipe: operand side plus result side.
// master drives operands and out_ready; slave is the pipe itself.
interface and_pipe_if
    import and_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_all;
    logic             out_zero;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_y,
        input  out_all,
        input  out_zero
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_y,
        output out_all,
        output out_zero
    );

endinterface

// File: rtl/and_pipe_reg.sv
// One elastic register slot: valid bit, payload, and bubble-collapsing
// ready (an empty slot always accepts, whatever is downstream).
module and_pipe_reg
    import and_pipe_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          w_load;

    assign o_ready = !r_valid || i_ready;
    assign w_load  = o_ready && i_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (o_ready) begin
                r_valid <= i_valid;
            end
            if (w_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/and_pipe_stage.sv
// Flow-controlled Y = A & B with all-ones/all-zero flags over STAGES slots.
// Define AND_PIPE_STATS_EN to add stat_xfers / stat_stalls counters.
module and_pipe_stage
    import and_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CHUNK  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    and_pipe_if.slave         bus
`ifdef AND_PIPE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_xfers,
    output logic [STAT_W-1:0] stat_stalls
`endif
);

    localparam int  NCH = WIDTH / CHUNK;
    localparam int  SW  = stage_bits(WIDTH, CHUNK);
    localparam bit  OK  = legal_cfg(WIDTH, CHUNK, STAGES);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [NCH-1:0]   andp;
        logic [NCH-1:0]   norp;
        logic             all;
        logic             zero;
    } stg_t;

    logic [WIDTH-1:0] w_y0;
    logic [NCH-1:0]   w_andp0;
    logic [NCH-1:0]   w_norp0;
    logic [STAGES:0]  w_rdy;
    logic [STAGES-1:0] w_v;
    stg_t             w_q [STAGES];

    assign w_y0 = bus.in_a & bus.in_b;

    always_comb begin
        w_andp0 = '0;
        w_norp0 = '0;
        for (int c = 0; c < NCH; c++) begin
            w_andp0[c] = &w_y0[c*CHUNK +: CHUNK];
            w_norp0[c] = ~|w_y0[c*CHUNK +: CHUNK];
        end
    end

    assign w_rdy[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        stg_t w_src;
        stg_t w_d;
        logic w_vin;

        if (k == 0) begin : g_head
            assign w_vin = bus.in_valid;
            always_comb begin
                w_src      = '0;
                w_src.y    = w_y0;
                w_src.andp = w_andp0;
                w_src.norp = w_norp0;
            end
        end else begin : g_body
            assign w_vin = w_v[k-1];
            assign w_src = w_q[k-1];
        end

        // Last slot folds the partials so the flags leave straight from a flop.
        if (k == STAGES - 1) begin : g_tail
            always_comb begin
                w_d      = w_src;
                w_d.all  = &w_src.andp;
                w_d.zero = &w_src.norp;
            end
        end else begin : g_pass
            assign w_d = w_src;
        end

        and_pipe_reg #(
            .DW(SW)
        ) u_reg (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_vin),
            .o_ready (w_rdy[k]),
            .i_data  (w_d),
            .o_valid (w_v[k]),
            .i_ready (w_rdy[k+1]),
            .o_data  (w_q[k])
        );
    end

    assign bus.in_ready  = w_rdy[0] && OK;
    assign bus.out_valid = w_v[STAGES-1];
    assign bus.out_y     = w_q[STAGES-1].y;
    assign bus.out_all   = w_q[STAGES-1].all;
    assign bus.out_zero  = w_q[STAGES-1].zero;

`ifdef AND_PIPE_STATS_EN
    logic [STAT_W-1:0] r_xfers;
    logic [STAT_W-1:0] r_stalls;
    logic              w_xfer;
    logic              w_stall;

    assign w_xfer  = bus.out_valid && bus.out_ready;
    assign w_stall = bus.out_valid && !bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfers  <= '0;
            r_stalls <= '0;
        end else begin
            if (w_xfer) begin
                r_xfers <= r_xfers + 1'b1;
            end
            if (w_stall) begin
                r_stalls <= r_stalls + 1'b1;
            end
        end
    end

    assign stat_xfers  = r_xfers;
    assign stat_stalls = r_stalls;
`endif

endmodule

// File: tb/tb_and_pipe_stage.sv
// Directed bench for and_pipe_stage at STAGES = 1, 2 and 4.
// Stats checks are included when AND_PIPE_STATS_EN is defined.
module tb_and_pipe_stage;
    import and_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    and_pipe_if #(.WIDTH(32)) b1 ();
    and_pipe_if #(.WIDTH(32)) b2 ();
    and_pipe_if #(.WIDTH(32)) b4 ();

`ifdef AND_PIPE_STATS_EN
    logic [15:0] sx1, ss1, sx2, ss2, sx4, ss4;
`endif

    and_pipe_stage #(.WIDTH(32), .CHUNK(8), .STAGES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
`ifdef AND_PIPE_STATS_EN
        ,
        .stat_xfers  (sx2),
        .stat_stalls (ss2)
`endif
    );

    and_pipe_stage #(.WIDTH(32), .CHUNK(8), .STAGES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
`ifdef AND_PIPE_STATS_EN
        ,
        .stat_xfers  (sx1),
        .stat_stalls (ss1)
`endif
    );

    and_pipe_stage #(.WIDTH(32), .CHUNK(8), .STAGES(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
`ifdef AND_PIPE_STATS_EN
        ,
        .stat_xfers  (sx4),
        .stat_stalls (ss4)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic [31:0] a,
                          input logic [31:0] b);
        b2.in_valid = v;
        b2.in_a     = a;
        b2.in_b     = b;
    endtask

    task automatic drive14(input logic v, input logic [31:0] a,
                           input logic [31:0] b);
        b1.in_valid = v;
        b1.in_a     = a;
        b1.in_b     = b;
        b4.in_valid = v;
        b4.in_a     = a;
        b4.in_b     = b;
    endtask

    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic [31:0] te [8];

    logic [31:0] q1 [$];
    logic [31:0] q4 [$];
    int          c1 [$];
    int          c4 [$];

    initial begin
        int sent, got, held, r1, r4;
        logic rdy;
        logic [31:0] ra, rb, y;

        ta = '{32'hFFFFFFFF, 32'hF0F0F0F0, 32'h12345678, 32'hAAAAAAAA,
               32'hDEADBEEF, 32'h80000000, 32'h0F0F0F0F, 32'hCAFEBABE};
        tb = '{32'h00000001, 32'hFF00FF00, 32'hFFFF0000, 32'h55555555,
               32'h0000FFFF, 32'h80000001, 32'hFFFFFFFF, 32'hFF00FF00};
        te = '{32'h00000001, 32'hF000F000, 32'h12340000, 32'h00000000,
               32'h0000BEEF, 32'h80000000, 32'h0F0F0F0F, 32'hCA00BA00};

        drive2(1'b0, '0, '0);
        drive14(1'b0, '0, '0);
        b1.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        b4.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();

        check("rst_valid", b2.out_valid, 1'b0);
        check("rst_y", b2.out_y, 32'h0);
        check("rst_all", b2.out_all, 1'b0);
        check("rst_zero", b2.out_zero, 1'b0);
        check("rst_valid1", b1.out_valid, 1'b0);
        check("rst_valid4", b4.out_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", b2.in_ready, 1'b1);

        drive2(1'b1, 32'hFFFF0000, 32'h0F0F0F0F);
        step();
        drive2(1'b0, '0, '0);
        check("lat_early", b2.out_valid, 1'b0);
        step();
        check("lat_valid", b2.out_valid, 1'b1);
        check("lat_y", b2.out_y, 32'h0F0F0000);
        check("lat_all", b2.out_all, 1'b0);
        check("lat_zero", b2.out_zero, 1'b0);
        step();
        check("lat_gone", b2.out_valid, 1'b0);

        drive2(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        drive2(1'b1, 32'h12345678, 32'h0);
        step();
        drive2(1'b0, '0, '0);
        check("flg1_valid", b2.out_valid, 1'b1);
        check("flg1_y", b2.out_y, 32'hFFFFFFFF);
        check("flg1_all", b2.out_all, 1'b1);
        check("flg1_zero", b2.out_zero, 1'b0);
        step();
        check("flg2_valid", b2.out_valid, 1'b1);
        check("flg2_y", b2.out_y, 32'h0);
        check("flg2_all", b2.out_all, 1'b0);
        check("flg2_zero", b2.out_zero, 1'b1);
        step();
        check("flg_gone", b2.out_valid, 1'b0);

        sent = 0;
        got  = 0;
        held = 0;
        for (int c = 0; c < 80; c++) begin
            if (got == 8) break;
            rdy = (c % 4 == 0) || (c % 4 == 3);
            b2.out_ready = rdy;
            if (sent < 8) drive2(1'b1, ta[sent], tb[sent]);
            else drive2(1'b0, '0, '0);
            #1;
            check("bp_in_ready", b2.in_ready, (held < 2) || rdy);
            if (b2.out_valid) begin
                check("bp_y", b2.out_y, te[got]);
                check("bp_zero", b2.out_zero, te[got] == 32'h0);
                if (rdy) begin
                    got++;
                    held--;
                end
            end
            if (b2.in_valid && b2.in_ready) begin
                sent++;
                held++;
            end
            step();
        end
        check("bp_count", got, 8);
        drive2(1'b0, '0, '0);
        b2.out_ready = 1'b1;
        step();
        step();
        check("bp_drain", b2.out_valid, 1'b0);

        b2.out_ready = 1'b0;
        drive2(1'b1, 32'h11111111, 32'hFFFFFFFF);
        step();
        drive2(1'b1, 32'h22222222, 32'hFFFFFFFF);
        step();
        drive2(1'b1, 32'h33333333, 32'hFFFFFFFF);
        #1;
        check("mid_valid", b2.out_valid, 1'b1);
        check("mid_full", b2.in_ready, 1'b0);
        check("mid_y", b2.out_y, 32'h11111111);
        rst = 1'b1;
        step();
        check("mid_rst_valid", b2.out_valid, 1'b0);
        check("mid_rst_y", b2.out_y, 32'h0);
        rst = 1'b0;
        drive2(1'b0, '0, '0);
        b2.out_ready = 1'b1;
        #1;
        check("mid_in_ready", b2.in_ready, 1'b1);
        step();
        step();
        check("mid_dropped", b2.out_valid, 1'b0);
        drive2(1'b1, 32'h00FF00FF, 32'h0FF00FF0);
        step();
        drive2(1'b0, '0, '0);
        step();
        check("mid_resume_v", b2.out_valid, 1'b1);
        check("mid_resume_y", b2.out_y, 32'h00F000F0);
        step();

        r1 = 0;
        r4 = 0;
        for (int c = 0; c < 106; c++) begin
            if (c < 100) begin
                unique case (c)
                    0: begin ra = 32'hFFFFFFFF; rb = 32'hFFFFFFFF; end
                    1: begin ra = 32'h12345678; rb = 32'h0;        end
                    2: begin ra = 32'hFFFFFF7F; rb = 32'hFFFFFFFF; end
                    3: begin ra = 32'hFF00FF00; rb = 32'h00FF00FF; end
                    default: begin ra = $urandom; rb = $urandom; end
                endcase
                drive14(1'b1, ra, rb);
            end else begin
                drive14(1'b0, '0, '0);
            end
            #1;
            if (c < 100) begin
                check("tp_in_ready1", b1.in_ready, 1'b1);
                check("tp_in_ready4", b4.in_ready, 1'b1);
            end
            if (b1.out_valid) begin
                if (q1.size() > 0) begin
                    y = q1.pop_front();
                    check("tp1_y", b1.out_y, y);
                    check("tp1_all", b1.out_all, y == 32'hFFFFFFFF);
                    check("tp1_zero", b1.out_zero, y == 32'h0);
                    check("tp1_lat", c - c1.pop_front(), 1);
                    r1++;
                end else begin
                    check("tp1_spurious", b1.out_valid, 1'b0);
                end
            end
            if (b4.out_valid) begin
                if (q4.size() > 0) begin
                    y = q4.pop_front();
                    check("tp4_y", b4.out_y, y);
                    check("tp4_all", b4.out_all, y == 32'hFFFFFFFF);
                    check("tp4_zero", b4.out_zero, y == 32'h0);
                    check("tp4_lat", c - c4.pop_front(), 4);
                    r4++;
                end else begin
                    check("tp4_spurious", b4.out_valid, 1'b0);
                end
            end
            if (b1.in_valid && b1.in_ready) begin
                q1.push_back(b1.in_a & b1.in_b);
                c1.push_back(c);
            end
            if (b4.in_valid && b4.in_ready) begin
                q4.push_back(b4.in_a & b4.in_b);
                c4.push_back(c);
            end
            step();
        end
        check("tp1_count", r1, 100);
        check("tp4_count", r4, 100);

`ifdef AND_PIPE_STATS_EN
        rst = 1'b1;
        drive2(1'b0, '0, '0);
        b2.out_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("st_rst_x", sx2, 16'h0);
        check("st_rst_s", ss2, 16'h0);
        b2.out_ready = 1'b0;
        drive2(1'b1, 32'h1, 32'h1);
        step();
        drive2(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step();
        b2.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive2(1'b1, i, 32'hFFFFFFFF);
            step();
        end
        drive2(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step();
        check("st_xfers", sx2, 16'd10);
        check("st_stalls", ss2, 16'd3);
        for (int i = 0; i < 65525; i++) begin
            drive2(1'b1, i, 32'hFFFFFFFF);
            step();
        end
        drive2(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step();
        check("st_full", sx2, 16'hFFFF);
        drive2(1'b1, 32'h5, 32'h5);
        step();
        drive2(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step();
        check("st_wrap", sx2, 16'h0);
        check("st_stalls_kept", ss2, 16'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
